// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-driven initiator for the peripheral bus.
// Parses command frames from a byte-level UART receiver, issues one
// read or write on the peripheral bus, and streams a response frame
// to a byte-level UART transmitter.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_data/rx_valid           received byte + one-cycle strobe
//   tx_data/tx_valid/tx_ready  response byte handshake
//   peripheralEnable/_we/_oe   bus transaction strobes
//   peripheralBus_address      16-bit target address
//   peripheralBus_byteSelect   byte lanes from command[7:4]
//   peripheralBus_dataWrite    write data (LSB byte first on the wire)
//   peripheralBus_dataRead     read data, captured on completion
//   peripheralBus_busy         responder stall
//   active                     frame in progress (first byte to last response byte)
//
// Optional build macro UART_BUS_MASTER_CHECKSUM_EN: adds a trailing XOR
// checksum byte to every command and response frame (CHECK state).
module uart_bus_master #(
  parameter int unsigned BUS_TIMEOUT = 256,
  parameter int unsigned RX_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        peripheralEnable,
  output logic        peripheralBus_we,
  output logic        peripheralBus_oe,
  output logic [15:0] peripheralBus_address,
  output logic [3:0]  peripheralBus_byteSelect,
  output logic [31:0] peripheralBus_dataWrite,
  input  logic [31:0] peripheralBus_dataRead,
  input  logic        peripheralBus_busy,
  output logic        active
);

  localparam int unsigned BUS_CNT_W = $clog2(BUS_TIMEOUT + 1);
  localparam int unsigned RX_CNT_W  = $clog2(RX_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR0 = 3'd1;
  localparam logic [2:0] S_ADDR1 = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_BUS   = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd6;
  localparam logic [7:0] ST_CKSUM = 8'hE2;
`endif

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADOP   = 8'hEE;
  localparam logic [7:0] ST_TIMEOUT = 8'hE1;

  logic [2:0]           state_q, state_d;
  logic [RX_CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BUS_CNT_W-1:0] bus_cnt_q, bus_cnt_d;
  logic [1:0]           wcnt_q, wcnt_d;
  logic                 is_wr_q, is_wr_d;
  logic                 is_rd_q, is_rd_d;
  logic [3:0]           be_q, be_d;
  logic [15:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [7:0]           status_q, status_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 en_q, we_q, oe_q, active_q;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
  logic [7:0]           rx_xor_q, rx_xor_d;
  logic [7:0]           tx_xor_q, tx_xor_d;
`endif

  logic       collecting, rx_expire, start_resp, rd_ok;
  logic [7:0] resp_status;
  logic [2:0] last_idx;

  // Next-state, datapath and response sequencing
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    is_wr_d     = is_wr_q;
    is_rd_d     = is_rd_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    bus_cnt_d   = '0;
    start_resp  = 1'b0;
    resp_status = ST_OK;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    tx_xor_d    = tx_xor_q;
    rx_xor_d    = rx_xor_q;
    if (rx_valid) rx_xor_d = (state_q == S_IDLE) ? rx_data : (rx_xor_q ^ rx_data);
    collecting  = (state_q == S_ADDR0) || (state_q == S_ADDR1) ||
                  (state_q == S_WDATA) || (state_q == S_CHECK);
`else
    collecting  = (state_q == S_ADDR0) || (state_q == S_ADDR1) || (state_q == S_WDATA);
`endif
    // A byte on the expiry cycle wins over the timeout
    rx_expire = collecting && !rx_valid && (rx_cnt_q == RX_CNT_W'(RX_TIMEOUT - 1));
    rx_cnt_d  = (collecting && !rx_valid) ? rx_cnt_q + RX_CNT_W'(1) : '0;
    rd_ok     = is_rd_q && (status_q == ST_OK);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    last_idx  = rd_ok ? 3'd5 : 3'd1;
`else
    last_idx  = rd_ok ? 3'd4 : 3'd0;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          is_rd_d = (rx_data[3:0] == 4'h1);
          is_wr_d = (rx_data[3:0] == 4'h2);
          be_d    = rx_data[7:4];
          state_d = S_ADDR0;
        end
      end
      S_ADDR0: begin
        if (rx_valid) begin
          addr_d[7:0] = rx_data;
          state_d     = S_ADDR1;
        end else if (rx_expire) begin
          state_d = S_IDLE;
        end
      end
      S_ADDR1: begin
        if (rx_valid) begin
          addr_d[15:8] = rx_data;
          wcnt_d       = 2'd0;
          if (is_wr_q) begin
            state_d = S_WDATA;
          end else begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            if (is_rd_q) begin
              state_d = S_BUS;
            end else begin
              start_resp  = 1'b1;
              resp_status = ST_BADOP;
            end
`endif
          end
        end else if (rx_expire) begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          // Shift in from the top so the first byte ends up in [7:0]
          wdata_d = {rx_data, wdata_q[31:8]};
          wcnt_d  = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_BUS;
`endif
          end
        end else if (rx_expire) begin
          state_d = S_IDLE;
        end
      end
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data != rx_xor_q) begin
            start_resp  = 1'b1;
            resp_status = ST_CKSUM;
          end else if (is_wr_q || is_rd_q) begin
            state_d = S_BUS;
          end else begin
            start_resp  = 1'b1;
            resp_status = ST_BADOP;
          end
        end else if (rx_expire) begin
          state_d = S_IDLE;
        end
      end
`endif
      S_BUS: begin
        if (!peripheralBus_busy) begin
          rdata_d     = peripheralBus_dataRead;
          start_resp  = 1'b1;
          resp_status = ST_OK;
        end else if (bus_cnt_q == BUS_CNT_W'(BUS_TIMEOUT - 1)) begin
          start_resp  = 1'b1;
          resp_status = ST_TIMEOUT;
        end else begin
          bus_cnt_d = bus_cnt_q + BUS_CNT_W'(1);
        end
      end
      S_RESP: begin
        // tx_valid is always high here; each acceptance loads the next byte
        if (tx_ready) begin
          if (idx_q == last_idx) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
            if (rd_ok && (idx_q < 3'd4)) begin
              tx_data_d = rdata_q[7:0];
              rdata_d   = {8'h00, rdata_q[31:8]};
              tx_xor_d  = tx_xor_q ^ rdata_q[7:0];
            end else begin
              tx_data_d = tx_xor_q;
            end
`else
            tx_data_d = rdata_q[7:0];
            rdata_d   = {8'h00, rdata_q[31:8]};
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_resp) begin
      state_d    = S_RESP;
      status_d   = resp_status;
      idx_d      = 3'd0;
      tx_data_d  = resp_status;
      tx_valid_d = 1'b1;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      tx_xor_d   = resp_status;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      bus_cnt_q  <= '0;
      wcnt_q     <= '0;
      is_wr_q    <= 1'b0;
      is_rd_q    <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      active_q   <= 1'b0;
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      rx_xor_q   <= '0;
      tx_xor_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      bus_cnt_q  <= bus_cnt_d;
      wcnt_q     <= wcnt_d;
      is_wr_q    <= is_wr_d;
      is_rd_q    <= is_rd_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      // Strobes follow the BUS state exactly
      en_q       <= (state_d == S_BUS);
      we_q       <= (state_d == S_BUS) && is_wr_d;
      oe_q       <= (state_d == S_BUS) && is_rd_d;
      active_q   <= (state_d != S_IDLE);
`ifdef UART_BUS_MASTER_CHECKSUM_EN
      rx_xor_q   <= rx_xor_d;
      tx_xor_q   <= tx_xor_d;
`endif
    end
  end

  assign tx_data                  = tx_data_q;
  assign tx_valid                 = tx_valid_q;
  assign peripheralEnable         = en_q;
  assign peripheralBus_we         = we_q;
  assign peripheralBus_oe         = oe_q;
  assign peripheralBus_address    = addr_q;
  assign peripheralBus_byteSelect = be_q;
  assign peripheralBus_dataWrite  = wdata_q;
  assign active                   = active_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Testbench for uart_bus_master: directed and random frames against a
// frame-level reference model (expected bus activity and response bytes).
module tb_uart_bus_master;

  localparam int unsigned BT = 16;
  localparam int unsigned RT = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        peripheralEnable, peripheralBus_we, peripheralBus_oe;
  logic [15:0] peripheralBus_address;
  logic [3:0]  peripheralBus_byteSelect;
  logic [31:0] peripheralBus_dataWrite, peripheralBus_dataRead;
  logic        peripheralBus_busy;
  logic        active;

  uart_bus_master #(.BUS_TIMEOUT(BT), .RX_TIMEOUT(RT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .peripheralEnable(peripheralEnable),
    .peripheralBus_we(peripheralBus_we), .peripheralBus_oe(peripheralBus_oe),
    .peripheralBus_address(peripheralBus_address),
    .peripheralBus_byteSelect(peripheralBus_byteSelect),
    .peripheralBus_dataWrite(peripheralBus_dataWrite),
    .peripheralBus_dataRead(peripheralBus_dataRead),
    .peripheralBus_busy(peripheralBus_busy),
    .active(active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bus responder / monitor state
  int          busy_len = 0;
  int          bus_idx = 0;
  int          en_cycles, we_cycles, oe_cycles, en_bursts, bus_unstable, orphan;
  logic [15:0] mon_addr;
  logic [3:0]  mon_be;
  logic [31:0] mon_wd;
  logic        prev_en = 1'b0;

  // Transmit side state
  logic [7:0]  tx_got[$];
  int          tx_unstable;
  logic        prev_pend = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int          hold = 0;
  bit          stall_req = 1'b0;
  bit          rdy_random = 1'b1;

  logic [7:0]  frame[$];

  task automatic clear_mon();
    en_cycles = 0; we_cycles = 0; oe_cycles = 0; en_bursts = 0;
    bus_unstable = 0; orphan = 0; tx_unstable = 0;
    tx_got.delete();
  endtask

  // Sample bus and tx away from the active edge; drive busy for the next edge
  always @(negedge clk) begin
    if (peripheralEnable) begin
      if (!prev_en) begin
        en_bursts++;
        mon_addr = peripheralBus_address;
        mon_be   = peripheralBus_byteSelect;
        mon_wd   = peripheralBus_dataWrite;
      end else if (peripheralBus_address !== mon_addr || peripheralBus_byteSelect !== mon_be ||
                   peripheralBus_dataWrite !== mon_wd) begin
        bus_unstable++;
      end
      en_cycles++;
      if (peripheralBus_we) we_cycles++;
      if (peripheralBus_oe) oe_cycles++;
      peripheralBus_busy = (bus_idx < busy_len);
      bus_idx++;
    end else begin
      bus_idx = 0;
      peripheralBus_busy = 1'b0;
    end
    if ((peripheralBus_we || peripheralBus_oe) && !peripheralEnable) orphan++;
    prev_en = peripheralEnable;
    if (prev_pend && (!tx_valid || tx_data !== prev_data)) tx_unstable++;
    if (tx_valid && tx_ready) tx_got.push_back(tx_data);
    prev_pend = tx_valid && !tx_ready;
    prev_data = tx_data;
  end

  // Transmitter model: random or stalled ready
  always @(posedge clk) begin
    #1;
    if (stall_req && tx_valid) begin
      hold = 20;
      stall_req = 1'b0;
    end
    if (hold > 0) begin
      tx_ready = 1'b0;
      hold--;
    end else begin
      tx_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame();
    foreach (frame[i]) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_byte(frame[i]);
    end
  endtask

  task automatic add_cksum();
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (frame[i]) x = x ^ frame[i];
    frame.push_back(x);
`endif
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!active) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // One complete frame: model the expected outcome, drive, compare
  task automatic run_txn(input string name, input logic [7:0] cmd, input logic [15:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int bl, input bit stall);
    bit         is_wr, is_rd, ok;
    logic [7:0] status, x;
    logic [7:0] exp[$];
    int         exp_cycles;
    is_rd = (cmd[3:0] == 4'h1);
    is_wr = (cmd[3:0] == 4'h2);
    frame = '{cmd, addr[7:0], addr[15:8]};
    if (is_wr) for (int i = 0; i < 4; i++) frame.push_back(8'(wd >> (8 * i)));
    add_cksum();
    if (!is_wr && !is_rd) begin status = 8'hEE; exp_cycles = 0; end
    else if (bl >= int'(BT)) begin status = 8'hE1; exp_cycles = BT; end
    else begin status = 8'h00; exp_cycles = bl + 1; end
    exp = '{status};
    if (is_rd && status == 8'h00) for (int i = 0; i < 4; i++) exp.push_back(8'(rd >> (8 * i)));
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    x = 8'h00;
    foreach (exp[i]) x = x ^ exp[i];
    exp.push_back(x);
`else
    x = 8'h00;
`endif
    clear_mon();
    busy_len = bl;
    peripheralBus_dataRead = rd;
    stall_req = stall;
    send_frame();
    if (stall) begin
      repeat (8) @(posedge clk);
      send_byte(8'h01);
    end
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s done: active stuck high", name); end
    n_checks++; if (en_cycles !== exp_cycles) begin n_fail++; $display("FAIL %s enable_cycles: got %0d want %0d", name, en_cycles, exp_cycles); end
    n_checks++; if (we_cycles !== (is_wr ? exp_cycles : 0)) begin n_fail++; $display("FAIL %s we_cycles: got %0d want %0d", name, we_cycles, is_wr ? exp_cycles : 0); end
    n_checks++; if (oe_cycles !== (is_rd ? exp_cycles : 0)) begin n_fail++; $display("FAIL %s oe_cycles: got %0d want %0d", name, oe_cycles, is_rd ? exp_cycles : 0); end
    n_checks++; if (en_bursts !== ((is_wr || is_rd) ? 1 : 0)) begin n_fail++; $display("FAIL %s bursts: got %0d", name, en_bursts); end
    n_checks++; if (bus_unstable + orphan + tx_unstable !== 0) begin n_fail++; $display("FAIL %s stability: bus %0d orphan %0d tx %0d", name, bus_unstable, orphan, tx_unstable); end
    if (is_wr || is_rd) begin
      n_checks++; if (mon_addr !== addr || mon_be !== cmd[7:4]) begin n_fail++; $display("FAIL %s addr/be: got %h/%h want %h/%h", name, mon_addr, mon_be, addr, cmd[7:4]); end
    end
    if (is_wr) begin
      n_checks++; if (mon_wd !== wd) begin n_fail++; $display("FAIL %s dataWrite: got %h want %h", name, mon_wd, wd); end
    end
    n_checks++; if (tx_got.size() !== exp.size()) begin n_fail++; $display("FAIL %s resp_len: got %0d want %0d", name, tx_got.size(), exp.size()); end
    foreach (exp[i]) begin
      if (i < tx_got.size()) begin
        n_checks++; if (tx_got[i] !== exp[i]) begin n_fail++; $display("FAIL %s resp[%0d]: got %h want %h", name, i, tx_got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    peripheralBus_busy = 1'b0; peripheralBus_dataRead = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if ({tx_valid, tx_data} !== 9'h0) begin n_fail++; $display("FAIL reset tx: got %b/%h want 0/00", tx_valid, tx_data); end
    n_checks++; if ({peripheralEnable, peripheralBus_we, peripheralBus_oe, active} !== 4'b0) begin n_fail++; $display("FAIL reset strobes: got %b want 0000", {peripheralEnable, peripheralBus_we, peripheralBus_oe, active}); end
    n_checks++; if ({peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite} !== 52'h0) begin n_fail++; $display("FAIL reset bus: got %h/%h/%h want 0", peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    run_txn("write", 8'hF2, 16'h1008, 32'h12345678, 32'h0, 0, 1'b0);
  endtask

  task automatic test_read();
    run_txn("read", 8'h31, 16'h2000, 32'h0, 32'hDEADBEEF, 5, 1'b0);
  endtask

  task automatic test_bus_timeout();
    run_txn("bus_timeout", 8'h51, 16'h3000, 32'h0, 32'h11223344, 1000, 1'b0);
  endtask

  task automatic test_bad_opcode();
    run_txn("bad_opcode", 8'h05, 16'h4000, 32'h0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_rx_timeout();
    bit ok;
    clear_mon();
    send_byte(8'h02);
    send_byte(8'h00);
    repeat (90) @(negedge clk);
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL rx_timeout early: active got %b want 1", active); end
    repeat (25) @(negedge clk);
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL rx_timeout expire: active got %b want 0", active); end
    n_checks++; if (tx_got.size() !== 0 || en_cycles !== 0) begin n_fail++; $display("FAIL rx_timeout silent: tx %0d bus %0d want 0/0", tx_got.size(), en_cycles); end
    run_txn("after_rx_timeout", 8'h11, 16'hBEEF, 32'h0, 32'h0BADF00D, 2, 1'b0);
    // A byte landing on the exact expiry cycle must still be taken
    clear_mon();
    busy_len = 0;
    peripheralBus_dataRead = 32'hA5A55A5A;
    frame = '{8'hF1, 8'h34, 8'h12};
    add_cksum();
    send_byte(frame[0]);
    repeat (RT - 2) @(posedge clk);
    for (int i = 1; i < frame.size(); i++) send_byte(frame[i]);
    wait_idle(ok);
    n_checks++; if (en_cycles !== 1 || mon_addr !== 16'h1234) begin n_fail++; $display("FAIL rx_edge bus: cycles %0d addr %h want 1/1234", en_cycles, mon_addr); end
    n_checks++; if (tx_got.size() < 2 || tx_got[0] !== 8'h00 || tx_got[1] !== 8'h5A) begin n_fail++; $display("FAIL rx_edge resp: len %0d want status 00 then 5A", tx_got.size()); end
  endtask

  task automatic test_tx_stall();
    run_txn("tx_stall", 8'h31, 16'h0400, 32'h0, 32'hCAFEF00D, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    clear_mon();
    busy_len = 1000;
    frame = '{8'h21, 8'h00, 8'h50};
    add_cksum();
    send_frame();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({peripheralEnable, peripheralBus_oe, active, tx_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_mid: outputs got %b want 0000", {peripheralEnable, peripheralBus_oe, active, tx_valid}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    busy_len = 0;
    repeat (30) @(negedge clk);
    n_checks++; if (tx_got.size() !== 0) begin n_fail++; $display("FAIL reset_mid resp: got %0d bytes want 0", tx_got.size()); end
    run_txn("after_reset", 8'h82, 16'h0042, 32'h89ABCDEF, 32'h0, 1, 1'b0);
  endtask

`ifdef UART_BUS_MASTER_CHECKSUM_EN
  task automatic test_bad_checksum();
    bit ok;
    clear_mon();
    frame = '{8'h31, 8'h00, 8'h20};
    add_cksum();
    frame[3] = frame[3] ^ 8'hFF;
    send_frame();
    wait_idle(ok);
    n_checks++; if (en_cycles !== 0) begin n_fail++; $display("FAIL bad_cksum bus: got %0d cycles want 0", en_cycles); end
    n_checks++; if (tx_got.size() !== 2 || tx_got[0] !== 8'hE2 || tx_got[1] !== 8'hE2) begin n_fail++; $display("FAIL bad_cksum resp: len %0d want E2,E2", tx_got.size()); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] cmd;
    int         v;
    for (int n = 0; n < 20; n++) begin
      v = $urandom_range(0, 3);
      cmd[7:4] = 4'($urandom);
      if (v == 0) cmd[3:0] = 4'h1;
      else if (v == 1) cmd[3:0] = 4'h2;
      else if (v == 2) cmd[3:0] = 4'h1;
      else begin
        v = $urandom_range(0, 13);
        cmd[3:0] = (v == 0) ? 4'h0 : 4'(v + 2);
      end
      run_txn("random", cmd, 16'($urandom), $urandom, $urandom, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bus_timeout();
    test_bad_opcode();
    test_rx_timeout();
    test_tx_stall();
    test_reset_mid();
`ifdef UART_BUS_MASTER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
